// File: rtl/trigger_detector_if.sv
// Sample stream, trigger controls and capture handshake between the ADC path,
// the trigger qualifier and the Fifo capture logic.
interface trigger_detector_if #(
  parameter int DW = 12,
  parameter int PW = 16
);
  logic          sample_valid;
  logic [DW-1:0] DATA_IN;
  logic [DW-1:0] TRIG;
  logic          edge_sel;
  logic          auto_en;
  logic          capture_done;
  logic          trig_pulse;
  logic          trig_auto;
  logic          armed;
  logic [PW-1:0] period_cnt;
  logic          period_valid;

  modport slave (
    input  sample_valid, DATA_IN, TRIG, edge_sel, auto_en, capture_done,
    output trig_pulse, trig_auto, armed, period_cnt, period_valid
  );

  modport master (
    output sample_valid, DATA_IN, TRIG, edge_sel, auto_en, capture_done,
    input  trig_pulse, trig_auto, armed, period_cnt, period_valid
  );
endinterface

// File: rtl/trigger_detector.sv
// Qualifies the ADC sample stream against TRIG with hysteresis and edge polarity,
// fires a one-cycle capture start, then waits for capture completion and holdoff.
module trigger_detector #(
  parameter int DW           = 12,
  parameter int HYST         = 16,
  parameter int HOLDOFF      = 64,
  parameter int AUTO_TIMEOUT = 4096,
  parameter int PW           = 16
) (
  input  logic              CLK,
  input  logic              reset,
  trigger_detector_if.slave bus
);
  localparam int AW = $clog2(AUTO_TIMEOUT);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [DW-1:0] HYST_D    = DW'(HYST);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_TIMEOUT - 1);
  localparam logic [AW-1:0] AUTO_ONE  = AW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [PW-1:0] PER_MAX   = {PW{1'b1}};
  localparam logic [PW-1:0] PER_ONE   = PW'(1);

  typedef enum logic [2:0] {
    ST_PRE,
    ST_ARMED,
    ST_FIRE,
    ST_WAIT_DONE,
    ST_HOLDOFF
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic          period_valid_q, period_valid_d;
  logic          trig_auto_q, trig_auto_d;
  logic          first_trig_q, first_trig_d;

  logic [DW-1:0] lo, hi;
  logic [DW:0]   hi_sum;
  logic          pre_met, fire_met, timeout;
  logic          fire_real, fire_auto;

  // Saturating hysteresis band around the live trigger level.
  assign lo       = (bus.TRIG >= HYST_D) ? (bus.TRIG - HYST_D) : '0;
  assign hi_sum   = {1'b0, bus.TRIG} + {1'b0, HYST_D};
  assign hi       = hi_sum[DW] ? {DW{1'b1}} : hi_sum[DW-1:0];
  assign pre_met  = bus.edge_sel ? (bus.DATA_IN > hi) : (bus.DATA_IN < lo);
  assign fire_met = bus.edge_sel ? (bus.DATA_IN <= bus.TRIG) : (bus.DATA_IN >= bus.TRIG);
  assign timeout  = bus.auto_en && (auto_cnt_q == AUTO_LAST);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= ST_PRE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fire_real = 1'b0;
    fire_auto = 1'b0;
    unique case (state_q)
      ST_PRE: begin
        if (bus.sample_valid) begin
          if (timeout) begin
            state_d   = ST_FIRE;
            fire_auto = 1'b1;
          end else if (pre_met) begin
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        // A real crossing outranks a timeout landing on the same sample.
        if (bus.sample_valid) begin
          if (fire_met) begin
            state_d   = ST_FIRE;
            fire_real = 1'b1;
          end else if (timeout) begin
            state_d   = ST_FIRE;
            fire_auto = 1'b1;
          end
        end
      end
      ST_FIRE:      state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.capture_done) state_d = ST_HOLDOFF;
      ST_HOLDOFF:   if (bus.sample_valid && (hold_cnt_q == HOLD_LAST)) state_d = ST_PRE;
      default:      state_d = ST_PRE;
    endcase
  end

  always_comb begin
    auto_cnt_d     = auto_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    per_cnt_d      = per_cnt_q;
    period_cnt_d   = period_cnt_q;
    period_valid_d = 1'b0;
    trig_auto_d    = fire_auto;
    first_trig_d   = first_trig_q;
    if (bus.sample_valid) begin
      if (!bus.auto_en || fire_real || fire_auto) begin
        auto_cnt_d = '0;
      end else if (state_q == ST_PRE || state_q == ST_ARMED) begin
        auto_cnt_d = auto_cnt_q + AUTO_ONE;
      end
      // The firing sample itself counts as the first sample of the new period.
      if (fire_real) begin
        per_cnt_d    = PER_ONE;
        first_trig_d = 1'b0;
        if (!first_trig_q) begin
          period_cnt_d   = per_cnt_q;
          period_valid_d = 1'b1;
        end
      end else if (per_cnt_q != PER_MAX) begin
        per_cnt_d = per_cnt_q + PER_ONE;
      end
      if (fire_auto) first_trig_d = 1'b1;
    end
    if (state_q == ST_WAIT_DONE && bus.capture_done) begin
      hold_cnt_d = '0;
    end else if (state_q == ST_HOLDOFF && bus.sample_valid) begin
      hold_cnt_d = hold_cnt_q + HOLD_ONE;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      auto_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      per_cnt_q      <= '0;
      period_cnt_q   <= '0;
      period_valid_q <= 1'b0;
      trig_auto_q    <= 1'b0;
      first_trig_q   <= 1'b1;
    end else begin
      auto_cnt_q     <= auto_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      per_cnt_q      <= per_cnt_d;
      period_cnt_q   <= period_cnt_d;
      period_valid_q <= period_valid_d;
      trig_auto_q    <= trig_auto_d;
      first_trig_q   <= first_trig_d;
    end
  end

  always_comb begin
    bus.trig_pulse   = (state_q == ST_FIRE);
    bus.armed        = (state_q == ST_ARMED);
    bus.trig_auto    = trig_auto_q;
    bus.period_valid = period_valid_q;
    bus.period_cnt   = period_cnt_q;
  end
endmodule

// File: tb/tb_trigger_detector.sv
// Self-checking bench for trigger_detector: directed scenarios plus random
// stimulus, all compared every cycle against a behavioural reference model.
module tb_trigger_detector;
  localparam int DW           = 12;
  localparam int HYST         = 16;
  localparam int HOLDOFF      = 64;
  localparam int AUTO_TIMEOUT = 4096;
  localparam int PW           = 16;
  localparam int DMAX         = (1 << DW) - 1;
  localparam int PMAX         = (1 << PW) - 1;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  trigger_detector_if #(.DW(DW), .PW(PW)) bus ();

  trigger_detector #(
    .DW(DW), .HYST(HYST), .HOLDOFF(HOLDOFF), .AUTO_TIMEOUT(AUTO_TIMEOUT), .PW(PW)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulses_seen = 0;
  int pv_seen     = 0;

  // Reference model: capture progress is tracked as "pulse due", "capture
  // outstanding" and "samples of holdoff left"; periods come from sample indices.
  bit m_pulse, m_auto, m_pv, m_armed, m_busy;
  int m_hold_left, m_auto_seen, m_period, m_last_real, n_samples;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pulse = 0; m_auto = 0; m_pv = 0; m_armed = 0; m_busy = 0;
    m_hold_left = 0; m_auto_seen = 0; m_period = 0; m_last_real = -1; n_samples = 0;
  endtask

  task automatic model_step();
    int  d, t, lo, hi;
    bit  was_pulse, real_fire, tout;
    was_pulse = m_pulse;
    m_pulse = 0; m_auto = 0; m_pv = 0;
    if (bus.sample_valid) begin
      n_samples++;
      if (!bus.auto_en) m_auto_seen = 0;
    end
    if (was_pulse) begin
      m_busy = 1;
    end else if (m_busy) begin
      if (bus.capture_done) begin
        m_busy = 0;
        m_hold_left = HOLDOFF;
      end
    end else if (m_hold_left > 0) begin
      if (bus.sample_valid) m_hold_left--;
    end else if (bus.sample_valid) begin
      d  = int'(bus.DATA_IN);
      t  = int'(bus.TRIG);
      lo = (t - HYST < 0) ? 0 : t - HYST;
      hi = (t + HYST > DMAX) ? DMAX : t + HYST;
      real_fire = m_armed && (bus.edge_sel ? (d <= t) : (d >= t));
      tout      = bus.auto_en && (m_auto_seen == AUTO_TIMEOUT - 1);
      if (real_fire) begin
        m_pulse = 1; m_armed = 0; m_auto_seen = 0;
        if (m_last_real >= 0) begin
          m_pv = 1;
          m_period = (n_samples - m_last_real > PMAX) ? PMAX : n_samples - m_last_real;
        end
        m_last_real = n_samples;
      end else if (tout) begin
        m_pulse = 1; m_auto = 1; m_armed = 0; m_auto_seen = 0; m_last_real = -1;
      end else begin
        if (!m_armed && (bus.edge_sel ? (d > hi) : (d < lo))) m_armed = 1;
        if (bus.auto_en) m_auto_seen++;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    chk("trig_pulse", bus.trig_pulse, m_pulse);
    chk("trig_auto", bus.trig_auto, m_auto);
    chk("armed", bus.armed, m_armed);
    chk("period_valid", bus.period_valid, m_pv);
    chk("period_cnt", bus.period_cnt, m_period);
    if (bus.trig_pulse === 1'b1) pulses_seen++;
    if (bus.period_valid === 1'b1) pv_seen++;
  endtask

  task automatic smp(input int d);
    bus.sample_valid = 1'b1;
    bus.DATA_IN      = d[DW-1:0];
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    bus.capture_done = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pulse", bus.trig_pulse, 0);
    chk("rst_auto", bus.trig_auto, 0);
    chk("rst_armed", bus.armed, 0);
    chk("rst_pv", bus.period_valid, 0);
    chk("rst_period", bus.period_cnt, 0);
    reset = 1'b0;
  endtask

  initial begin
    int p0, j, cd_at, d;
    bus.sample_valid = 0; bus.DATA_IN = '0; bus.TRIG = 12'd2048;
    bus.edge_sel = 0; bus.auto_en = 0; bus.capture_done = 0;
    reset = 1'b1;

    // Rising ramp
    do_reset();
    smp(2000); chk("ramp_armed", bus.armed, 1);
    smp(2031); smp(2040);
    smp(2048); chk("ramp_pulse", bus.trig_pulse, 1); chk("ramp_auto", bus.trig_auto, 0);
    tick();    chk("ramp_pulse_width", bus.trig_pulse, 0);

    // Hysteresis reject, then a real crossing
    do_reset();
    p0 = pulses_seen;
    for (int i = 0; i < 20; i++) smp((i % 2 == 0) ? 2040 : 2050);
    chk("hyst_no_arm", bus.armed, 0);
    chk("hyst_no_pulse", pulses_seen - p0, 0);
    smp(2031); chk("hyst_armed", bus.armed, 1);
    smp(2050); chk("hyst_single", pulses_seen - p0, 1);

    // Falling edge with clamped upper threshold
    do_reset();
    bus.edge_sel = 1; bus.TRIG = 12'd4090;
    smp(4095); chk("fall_clamp_no_arm", bus.armed, 0);
    bus.TRIG = 12'd100;
    smp(200);  chk("fall_armed", bus.armed, 1);
    smp(100);  chk("fall_pulse", bus.trig_pulse, 1);
    bus.edge_sel = 0; bus.TRIG = 12'd2048;

    // Auto fire exactly on the AUTO_TIMEOUT-th sample
    do_reset();
    bus.auto_en = 1;
    p0 = pulses_seen;
    for (int i = 1; i < AUTO_TIMEOUT; i++) smp(0);
    chk("auto_early", pulses_seen - p0, 0);
    smp(0); chk("auto_pulse", bus.trig_pulse, 1); chk("auto_flag", bus.trig_auto, 1);

    // Real crossing on the timeout sample wins
    do_reset();
    for (int i = 1; i < AUTO_TIMEOUT; i++) smp(0);
    smp(2048); chk("real_wins_pulse", bus.trig_pulse, 1); chk("real_wins_auto", bus.trig_auto, 0);

    // Auto disabled: never fires
    do_reset();
    bus.auto_en = 0;
    p0 = pulses_seen;
    for (int i = 0; i < 10000; i++) smp(0);
    chk("auto_off_no_pulse", pulses_seen - p0, 0);

    // Holdoff / re-arm with a square wave, capture_done 50 CLK after each fire
    do_reset();
    p0 = pulses_seen; j = 0; cd_at = -1;
    pv_seen = 0;
    for (int c = 0; c < 2400; c++) begin
      bus.sample_valid = (c % 4 == 0);
      if (c % 4 == 0) begin
        bus.DATA_IN = ((j / 50) % 2 == 0) ? 12'd1000 : 12'd3000;
        j++;
      end
      bus.capture_done = (c == cd_at);
      tick();
      if (bus.trig_pulse === 1'b1) cd_at = c + 50;
      if (bus.period_valid === 1'b1) chk("holdoff_period", bus.period_cnt, 100);
    end
    bus.sample_valid = 0; bus.capture_done = 0;
    chk("holdoff_pulses", pulses_seen - p0, 6);
    chk("holdoff_pv_count", pv_seen, 5);

    // Async reset while the pulse is high, then a fresh PRE->ARMED is needed
    do_reset();
    smp(2000); smp(2048);
    chk("async_pulse_before", bus.trig_pulse, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_pulse", bus.trig_pulse, 0);
    chk("async_armed", bus.armed, 0);
    chk("async_auto", bus.trig_auto, 0);
    do_reset();
    smp(2048); chk("async_no_refire", bus.trig_pulse, 0);
    smp(2000); chk("async_rearm", bus.armed, 1);
    smp(2048); chk("async_fire", bus.trig_pulse, 1);

    // Random stimulus against the model
    do_reset();
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 199) == 0) bus.edge_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) bus.auto_en  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) begin
        case ($urandom_range(0, 4))
          0:       bus.TRIG = 12'd5;
          1:       bus.TRIG = 12'd4090;
          default: bus.TRIG = 12'($urandom_range(0, DMAX));
        endcase
      end
      bus.sample_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 7) begin
        d = int'(bus.TRIG) + int'($urandom_range(0, 80)) - 40;
        if (d < 0) d = 0;
        if (d > DMAX) d = DMAX;
      end else begin
        d = int'($urandom_range(0, DMAX));
      end
      bus.DATA_IN = d[DW-1:0];
      bus.capture_done = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/trigger_detector.md
Name: trigger_detector

Overview:
- Sample-domain trigger qualifier between ADCmodule output (Readed_data) and the Fifo capture logic.
- Watches the 12-bit sample stream against the user trigger level TRIG, from trigger_adjust, with programmable hysteresis and edge polarity.
- Issues a single-cycle trigger pulse that starts a Fifo capture, then waits for capture completion and a holdoff interval before re-arming.
- Auto mode forces a trigger after a sample-count timeout so the trace never freezes; also reports the sample count between consecutive real triggers.

Parameters:
- DW, 12, sample and trigger-level width
- HYST, 16, hysteresis in LSBs required before arming
- HOLDOFF, 64, valid samples ignored after capture_done before re-arming (>=1)
- AUTO_TIMEOUT, 4096, valid samples without a real trigger before auto-fire (>=2)
- PW, 16, width of period_cnt

Ports:
- CLK  input  1  system clock (50 MHz)
- reset  input  1  asynchronous active-high reset
- sample_valid  input  1  one-CLK strobe per new ADC sample (ADC_CLK edge already synchronised to CLK)
- DATA_IN  input  DW  sample, qualified by sample_valid
- TRIG  input  DW  trigger level, sampled live on every valid sample
- edge_sel  input  1  0 = rising edge, 1 = falling edge
- auto_en  input  1  1 enables auto-fire timeout
- capture_done  input  1  one-CLK pulse from Fifo when the capture is complete
- trig_pulse  output  1  one-CLK capture-start pulse
- trig_auto  output  1  high together with trig_pulse when the fire was a timeout
- armed  output  1  high in ARMED state
- period_cnt  output  PW  valid samples between the last two real triggers, saturating
- period_valid  output  1  one-CLK pulse when period_cnt updates

Behaviour:
- Reset (async, active-high): state = PRE; all outputs 0; auto counter, holdoff counter and period counter = 0; first_trig flag = 1.
- All state changes except capture_done handling happen only on CLK edges where sample_valid = 1.
- Threshold arithmetic is unsigned DW-bit with saturation:
  - lo = TRIG-HYST, clamped at 0
  - hi = TRIG+HYST, clamped at 2^DW-1
- States:
  - PRE: waits for the pre-condition. Rising: DATA_IN < lo. Falling: DATA_IN > hi. Met -> ARMED.
  - ARMED: fire condition. Rising: DATA_IN >= TRIG. Falling: DATA_IN <= TRIG. Met -> FIRE.
  - FIRE: trig_pulse = 1 for exactly one CLK, registered on the CLK edge after the qualifying sample edge (latency 1 CLK). Then unconditionally -> WAIT_DONE.
  - WAIT_DONE: waits for capture_done (acted on any CLK, independent of sample_valid) -> HOLDOFF with holdoff counter cleared.
  - HOLDOFF: counts valid samples. After HOLDOFF valid samples -> PRE.
- A sample that completes PRE is not also evaluated for ARMED; each state transition consumes one sample.
- Auto counter:
  - Increments on each valid sample in PRE or ARMED; cleared on entering FIRE and on reset.
  - When auto_en = 1 and the count reaches AUTO_TIMEOUT-1 on a valid sample: -> FIRE with trig_auto = 1 alongside trig_pulse.
  - If a real fire condition and the timeout occur on the same sample, the real trigger wins and trig_auto = 0.
  - auto_en = 0 holds the counter at 0.
- Period counter:
  - Increments on every valid sample, saturating at 2^PW-1.
  - On a real (non-auto) fire: period_cnt <= counter value, period_valid pulses with trig_pulse, counter reloads to 1.
  - The first real fire after reset or after any auto fire only reloads the counter; no period_valid.
  - Any auto fire sets first_trig.
- Ignored inputs:
  - capture_done outside WAIT_DONE.
  - sample_valid while in FIRE or WAIT_DONE, except that the period counter keeps counting.
- TRIG, edge_sel or auto_en changes take effect on the next valid sample; no re-arm is forced.
- Reset asserted mid-capture returns to PRE immediately; trig_pulse drops asynchronously.

Test Plan:
- Rising ramp: TRIG = 2048, HYST = 16. Samples 2000, 2031, 2040, 2048 -> armed rises after 2000. trig_pulse is one CLK high one CLK after the valid edge carrying 2048. trig_auto = 0.
- Hysteresis reject: TRIG = 2048. Samples oscillate 2040 <-> 2050, never below 2032 -> no armed, no trig_pulse. Then one sample 2031 followed by 2050 -> a single trig_pulse.
- Falling edge + saturation: edge_sel = 1, TRIG = 4090. Samples 4095 (hi clamps to 4095, not above it, so no arm), then TRIG = 100, samples 200, 100 -> arm on 200, fire on 100.
- Auto mode: auto_en = 1, AUTO_TIMEOUT = 4096, constant input 0 with TRIG = 2048 -> trig_pulse and trig_auto together exactly at the 4096th valid sample. With auto_en = 0 -> no pulse after 10000 samples.
- Holdoff/re-arm: after a fire, square wave with period 100 samples; capture_done arrives 50 CLK later -> no second trig_pulse until 64 valid samples after capture_done. period_valid is reported with period_cnt = 100 on the second and later real triggers only.
- Async reset while in WAIT_DONE with trig_pulse pending -> all outputs 0 without a clock edge; next trigger requires a fresh PRE -> ARMED sequence.
